// File: rtl/rtc_calendar_counter.sv
// Calendar / time-of-day counter with prescaler, validated set port,
// Gregorian leap rules and single-cycle carry pulses.
module rtc_calendar_counter #(
   parameter int unsigned TICK_DIV   = 1,
   parameter int unsigned YEAR_W     = 16,
   parameter int unsigned INIT_YEAR  = 2023,
   parameter int unsigned INIT_MONTH = 5,
   parameter int unsigned INIT_DAY   = 9,
   parameter int unsigned INIT_WEEK  = 2
) (
   input  logic              secclk,
   input  logic              rst,
   input  logic              run,
   input  logic              set_valid,
   input  logic [YEAR_W-1:0] set_year,
   input  logic [3:0]        set_month,
   input  logic [4:0]        set_day,
   input  logic [4:0]        set_hour,
   input  logic [5:0]        set_minute,
   input  logic [5:0]        set_second,
   input  logic [2:0]        set_week,
   output logic [YEAR_W-1:0] year,
   output logic [3:0]        month,
   output logic [4:0]        day,
   output logic [4:0]        hour,
   output logic [5:0]        minute,
   output logic [5:0]        second,
   output logic [2:0]        week,
   output logic              sec_tick,
   output logic              min_carry,
   output logic              hour_carry,
   output logic              day_carry,
   output logic              set_ok,
   output logic              set_err
);

   localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PRESC_W-1:0] r_presc;
   logic [YEAR_W-1:0]  r_year;
   logic [3:0]         r_month;
   logic [4:0]         r_day;
   logic [4:0]         r_hour;
   logic [5:0]         r_minute;
   logic [5:0]         r_second;
   logic [2:0]         r_week;
   logic               r_sec_tick;
   logic               r_min_carry;
   logic               r_hour_carry;
   logic               r_day_carry;
   logic               r_set_ok;
   logic               r_set_err;

   logic               w_tick;
   logic               w_set_good;
   logic [4:0]         w_dim_cur;
   logic [4:0]         w_dim_set;

   function automatic logic is_leap(input logic [YEAR_W-1:0] y);
      logic [YEAR_W-1:0] r100;
      logic [YEAR_W-1:0] r400;
      r100 = y % YEAR_W'(100);
      r400 = y % YEAR_W'(400);
      return (y[1:0] == 2'd0) && ((r100 != '0) || (r400 == '0));
   endfunction

   function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [YEAR_W-1:0] y);
      logic [4:0] d;
      case (m)
         4'd2:                     d = is_leap(y) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:  d = 5'd30;
         default:                  d = 5'd31;
      endcase
      return d;
   endfunction

   assign w_tick    = run && (r_presc == PRESC_W'(TICK_DIV - 1));
   assign w_dim_cur = days_in_month(r_month, r_year);
   assign w_dim_set = days_in_month(set_month, set_year);

   assign w_set_good = (set_month >= 4'd1) && (set_month <= 4'd12)
                    && (set_day >= 5'd1) && (set_day <= w_dim_set)
                    && (set_hour <= 5'd23) && (set_minute <= 6'd59)
                    && (set_second <= 6'd59)
                    && (set_week >= 3'd1) && (set_week <= 3'd7);

   // Reset > accepted set > tick; a rejected set lets the prescaler run on.
   always_ff @(posedge secclk) begin
      if (rst) begin
         r_presc      <= '0;
         r_year       <= YEAR_W'(INIT_YEAR);
         r_month      <= 4'(INIT_MONTH);
         r_day        <= 5'(INIT_DAY);
         r_hour       <= 5'd0;
         r_minute     <= 6'd0;
         r_second     <= 6'd0;
         r_week       <= 3'(INIT_WEEK);
         r_sec_tick   <= 1'b0;
         r_min_carry  <= 1'b0;
         r_hour_carry <= 1'b0;
         r_day_carry  <= 1'b0;
         r_set_ok     <= 1'b0;
         r_set_err    <= 1'b0;
      end else begin
         r_sec_tick   <= 1'b0;
         r_min_carry  <= 1'b0;
         r_hour_carry <= 1'b0;
         r_day_carry  <= 1'b0;
         r_set_ok     <= 1'b0;
         r_set_err    <= 1'b0;
         if (set_valid && w_set_good) begin
            r_presc  <= '0;
            r_year   <= set_year;
            r_month  <= set_month;
            r_day    <= set_day;
            r_hour   <= set_hour;
            r_minute <= set_minute;
            r_second <= set_second;
            r_week   <= set_week;
            r_set_ok <= 1'b1;
         end else begin
            r_set_err <= set_valid;
            if (w_tick) begin
               r_presc    <= '0;
               r_sec_tick <= 1'b1;
               // Whole cascade resolves on this edge.
               if (r_second >= 6'd59) begin
                  r_second    <= 6'd0;
                  r_min_carry <= 1'b1;
                  if (r_minute >= 6'd59) begin
                     r_minute     <= 6'd0;
                     r_hour_carry <= 1'b1;
                     if (r_hour >= 5'd23) begin
                        r_hour      <= 5'd0;
                        r_day_carry <= 1'b1;
                        r_week      <= (r_week >= 3'd7) ? 3'd1 : r_week + 3'd1;
                        if (r_day >= w_dim_cur) begin
                           r_day <= 5'd1;
                           if (r_month >= 4'd12) begin
                              r_month <= 4'd1;
                              r_year  <= r_year + YEAR_W'(1);
                           end else begin
                              r_month <= r_month + 4'd1;
                           end
                        end else begin
                           r_day <= r_day + 5'd1;
                        end
                     end else begin
                        r_hour <= r_hour + 5'd1;
                     end
                  end else begin
                     r_minute <= r_minute + 6'd1;
                  end
               end else begin
                  r_second <= r_second + 6'd1;
               end
            end else if (run) begin
               r_presc <= r_presc + PRESC_W'(1);
            end
         end
      end
   end

   assign year       = r_year;
   assign month      = r_month;
   assign day        = r_day;
   assign hour       = r_hour;
   assign minute     = r_minute;
   assign second     = r_second;
   assign week       = r_week;
   assign sec_tick   = r_sec_tick;
   assign min_carry  = r_min_carry;
   assign hour_carry = r_hour_carry;
   assign day_carry  = r_day_carry;
   assign set_ok     = r_set_ok;
   assign set_err    = r_set_err;

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// Directed bench: one instance with TICK_DIV=1, one with TICK_DIV=4, shared inputs.
module tb_rtc_calendar_counter;

   logic        secclk = 1'b0;
   logic        rst, run, set_valid;
   logic [15:0] set_year;
   logic [3:0]  set_month;
   logic [4:0]  set_day, set_hour;
   logic [5:0]  set_minute, set_second;
   logic [2:0]  set_week;

   logic [15:0] a_year, b_year;
   logic [3:0]  a_month, b_month;
   logic [4:0]  a_day, b_day, a_hour, b_hour;
   logic [5:0]  a_minute, b_minute, a_second, b_second;
   logic [2:0]  a_week, b_week;
   logic        a_st, a_mc, a_hc, a_dc, a_ok, a_err;
   logic        b_st, b_mc, b_hc, b_dc, b_ok, b_err;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 secclk = ~secclk;

   rtc_calendar_counter #(.TICK_DIV(1)) u_dut1 (
      .secclk(secclk), .rst(rst), .run(run), .set_valid(set_valid),
      .set_year(set_year), .set_month(set_month), .set_day(set_day),
      .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
      .set_week(set_week),
      .year(a_year), .month(a_month), .day(a_day), .hour(a_hour),
      .minute(a_minute), .second(a_second), .week(a_week),
      .sec_tick(a_st), .min_carry(a_mc), .hour_carry(a_hc), .day_carry(a_dc),
      .set_ok(a_ok), .set_err(a_err));

   rtc_calendar_counter #(.TICK_DIV(4)) u_dut4 (
      .secclk(secclk), .rst(rst), .run(run), .set_valid(set_valid),
      .set_year(set_year), .set_month(set_month), .set_day(set_day),
      .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
      .set_week(set_week),
      .year(b_year), .month(b_month), .day(b_day), .hour(b_hour),
      .minute(b_minute), .second(b_second), .week(b_week),
      .sec_tick(b_st), .min_carry(b_mc), .hour_carry(b_hc), .day_carry(b_dc),
      .set_ok(b_ok), .set_err(b_err));

   // Packed views: {year,month,day,hour,minute,second,week} and
   // {sec_tick,min_carry,hour_carry,day_carry,set_ok,set_err}
   function automatic logic [44:0] a_state();
      return {a_year, a_month, a_day, a_hour, a_minute, a_second, a_week};
   endfunction
   function automatic logic [5:0] a_pulse();
      return {a_st, a_mc, a_hc, a_dc, a_ok, a_err};
   endfunction
   function automatic logic [5:0] b_pulse();
      return {b_st, b_mc, b_hc, b_dc, b_ok, b_err};
   endfunction

   task automatic step();
      @(posedge secclk);
      #1;
   endtask

   task automatic drive_set(input logic [15:0] y, input logic [3:0] m, input logic [4:0] d,
                            input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s,
                            input logic [2:0] w);
      set_valid  = 1'b1;
      set_year   = y;
      set_month  = m;
      set_day    = d;
      set_hour   = h;
      set_minute = mi;
      set_second = s;
      set_week   = w;
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b0; set_valid = 1'b0;
      step();
      step();
      n_cmp++;
      if (a_state() !== {16'd2023, 4'd5, 5'd9, 5'd0, 6'd0, 6'd0, 3'd2}) begin
         n_fail++;
         $display("FAIL reset_state got=%h want=%h", a_state(),
                  {16'd2023, 4'd5, 5'd9, 5'd0, 6'd0, 6'd0, 3'd2});
      end
      n_cmp++;
      if (a_pulse() !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_pulses got=%b want=000000", a_pulse());
      end
      rst = 1'b0; run = 1'b1;
      step();
      n_cmp++;
      if (a_second !== 6'd1 || a_st !== 1'b1) begin
         n_fail++;
         $display("FAIL first_tick got sec=%0d tick=%b want sec=1 tick=1", a_second, a_st);
      end
   endtask

   task automatic test_year_wrap();
      drive_set(16'd2023, 4'd12, 5'd31, 5'd23, 6'd59, 6'd59, 3'd7);
      step();
      n_cmp++;
      if (a_state() !== {16'd2023, 4'd12, 5'd31, 5'd23, 6'd59, 6'd59, 3'd7} || a_pulse() !== 6'b000010) begin
         n_fail++;
         $display("FAIL set_load got=%h pulses=%b want pulses=000010", a_state(), a_pulse());
      end
      set_valid = 1'b0;
      step();
      n_cmp++;
      if (a_state() !== {16'd2024, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, 3'd1}) begin
         n_fail++;
         $display("FAIL year_wrap got=%h want=%h", a_state(),
                  {16'd2024, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, 3'd1});
      end
      n_cmp++;
      if (a_pulse() !== 6'b111100) begin
         n_fail++;
         $display("FAIL year_wrap_pulses got=%b want=111100", a_pulse());
      end
      run = 1'b0;
      step();
      n_cmp++;
      if (a_pulse() !== 6'b0) begin
         n_fail++;
         $display("FAIL pulse_width got=%b want=000000", a_pulse());
      end
   endtask

   task automatic test_leap();
      logic [15:0] yrs [3];
      logic [3:0]  exp_m [3];
      logic [4:0]  exp_d [3];
      yrs[0] = 16'd2000; exp_m[0] = 4'd2; exp_d[0] = 5'd29;
      yrs[1] = 16'd2100; exp_m[1] = 4'd3; exp_d[1] = 5'd1;
      yrs[2] = 16'd2024; exp_m[2] = 4'd2; exp_d[2] = 5'd29;
      for (int i = 0; i < 3; i++) begin
         run = 1'b1;
         drive_set(yrs[i], 4'd2, 5'd28, 5'd23, 6'd59, 6'd59, 3'd3);
         step();
         set_valid = 1'b0;
         step();
         run = 1'b0;
         n_cmp++;
         if ({a_year, a_month, a_day, a_week, a_dc} !== {yrs[i], exp_m[i], exp_d[i], 3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL leap_%0d got %0d-%0d-%0d wk=%0d dc=%b want %0d-%0d-%0d wk=4 dc=1",
                     yrs[i], a_year, a_month, a_day, a_week, a_dc, yrs[i], exp_m[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_invalid_set();
      // Time frozen so any state change would be from the set itself.
      run = 1'b0;
      drive_set(16'd2023, 4'd2, 5'd29, 5'd1, 6'd2, 6'd3, 3'd1);
      step();
      n_cmp++;
      if (a_state() !== {16'd2024, 4'd2, 5'd29, 5'd0, 6'd0, 6'd0, 3'd4} || a_pulse() !== 6'b000001) begin
         n_fail++;
         $display("FAIL inv_feb29 got=%h pulses=%b want pulses=000001", a_state(), a_pulse());
      end
      drive_set(16'd2024, 4'd3, 5'd1, 5'd24, 6'd0, 6'd0, 3'd1);
      step();
      n_cmp++;
      if (a_state() !== {16'd2024, 4'd2, 5'd29, 5'd0, 6'd0, 6'd0, 3'd4} || a_pulse() !== 6'b000001) begin
         n_fail++;
         $display("FAIL inv_hour24 got=%h pulses=%b want pulses=000001", a_state(), a_pulse());
      end
      drive_set(16'd2024, 4'd3, 5'd1, 5'd1, 6'd0, 6'd0, 3'd0);
      step();
      n_cmp++;
      if (a_state() !== {16'd2024, 4'd2, 5'd29, 5'd0, 6'd0, 6'd0, 3'd4} || a_pulse() !== 6'b000001) begin
         n_fail++;
         $display("FAIL inv_week0 got=%h pulses=%b want pulses=000001", a_state(), a_pulse());
      end
      drive_set(16'd2024, 4'd4, 5'd31, 5'd1, 6'd0, 6'd0, 3'd1);
      step();
      n_cmp++;
      if (a_err !== 1'b1 || a_ok !== 1'b0) begin
         n_fail++;
         $display("FAIL inv_apr31 got ok=%b err=%b want ok=0 err=1", a_ok, a_err);
      end
      set_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      run = 1'b0;
      drive_set(16'd2025, 4'd7, 5'd4, 5'd12, 6'd30, 6'd15, 3'd5);
      step();
      n_cmp++;
      if (a_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first got ok=%b want ok=1", a_ok);
      end
      set_minute = 6'd31;
      step();
      n_cmp++;
      if (a_ok !== 1'b1 || a_minute !== 6'd31) begin
         n_fail++;
         $display("FAIL b2b_second got ok=%b min=%0d want ok=1 min=31", a_ok, a_minute);
      end
      set_valid = 1'b0;
      step();
      n_cmp++;
      if (a_ok !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_release got ok=%b want ok=0", a_ok);
      end
   endtask

   task automatic test_prescaler();
      rst = 1'b1; run = 1'b0; set_valid = 1'b0;
      step();
      rst = 1'b0; run = 1'b1;
      repeat (3) step();
      n_cmp++;
      if (b_second !== 6'd0 || b_st !== 1'b0) begin
         n_fail++;
         $display("FAIL div4_early got sec=%0d tick=%b want sec=0 tick=0", b_second, b_st);
      end
      step();
      n_cmp++;
      if (b_second !== 6'd1 || b_st !== 1'b1) begin
         n_fail++;
         $display("FAIL div4_tick got sec=%0d tick=%b want sec=1 tick=1", b_second, b_st);
      end
      repeat (2) step();
      run = 1'b0;
      repeat (3) step();
      run = 1'b1;
      step();
      n_cmp++;
      if (b_second !== 6'd1) begin
         n_fail++;
         $display("FAIL div4_hold got sec=%0d want sec=1", b_second);
      end
      step();
      n_cmp++;
      if (b_second !== 6'd2 || b_st !== 1'b1) begin
         n_fail++;
         $display("FAIL div4_stretch got sec=%0d tick=%b want sec=2 tick=1", b_second, b_st);
      end
   endtask

   task automatic test_set_vs_tick();
      // Prescaler is 0 here; three edges bring it to terminal count.
      repeat (3) step();
      drive_set(16'd2030, 4'd6, 5'd15, 5'd10, 6'd20, 6'd30, 3'd5);
      step();
      n_cmp++;
      if (b_second !== 6'd30 || b_pulse() !== 6'b000010) begin
         n_fail++;
         $display("FAIL set_at_tc got sec=%0d pulses=%b want sec=30 pulses=000010", b_second, b_pulse());
      end
      set_valid = 1'b0;
      repeat (3) step();
      n_cmp++;
      if (b_second !== 6'd30) begin
         n_fail++;
         $display("FAIL presc_cleared got sec=%0d want sec=30", b_second);
      end
      step();
      n_cmp++;
      if (b_second !== 6'd31 || b_st !== 1'b1) begin
         n_fail++;
         $display("FAIL presc_after_set got sec=%0d tick=%b want sec=31 tick=1", b_second, b_st);
      end
      repeat (3) step();
      drive_set(16'd2030, 4'd6, 5'd15, 5'd24, 6'd0, 6'd0, 3'd5);
      step();
      n_cmp++;
      if (b_second !== 6'd32 || b_pulse() !== 6'b100001) begin
         n_fail++;
         $display("FAIL inv_set_ticks got sec=%0d pulses=%b want sec=32 pulses=100001", b_second, b_pulse());
      end
      set_valid = 1'b0;
   endtask

   task automatic test_rst_vs_set();
      run = 1'b1;
      rst = 1'b1;
      drive_set(16'd2040, 4'd1, 5'd2, 5'd3, 6'd4, 6'd5, 3'd6);
      step();
      n_cmp++;
      if (a_state() !== {16'd2023, 4'd5, 5'd9, 5'd0, 6'd0, 6'd0, 3'd2} || a_pulse() !== 6'b0) begin
         n_fail++;
         $display("FAIL rst_over_set got=%h pulses=%b want=%h pulses=000000", a_state(), a_pulse(),
                  {16'd2023, 4'd5, 5'd9, 5'd0, 6'd0, 6'd0, 3'd2});
      end
      rst = 1'b0; set_valid = 1'b0; run = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; set_valid = 1'b0;
      set_year = '0; set_month = '0; set_day = '0; set_hour = '0;
      set_minute = '0; set_second = '0; set_week = '0;
      test_reset();
      test_year_wrap();
      test_leap();
      test_invalid_set();
      test_back_to_back();
      test_prescaler();
      test_set_vs_tick();
      test_rst_vs_set();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
